// File: rtl/reset_sequencer.sv
// Sequenced multi-domain reset controller: debounced push-button plus staged
// release of N_STAGES reset domains, each gated on its acknowledge with timeout.
module reset_sequencer #(
  parameter int N_STAGES        = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int GAP_CYCLES      = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  input  logic                          i_rst_button,
  input  logic [N_STAGES-1:0]           i_ack,
  output logic [N_STAGES-1:0]           o_rst,
  output logic                          o_ready,
  output logic                          o_fault,
  output logic [1:0]                    o_dbg_state,
  output logic [$clog2(N_STAGES)-1:0]   o_dbg_stage
);

  localparam int SW      = $clog2(N_STAGES);
  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(ACK_TIMEOUT - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(N_STAGES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT   = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_GAP      = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            fault_d;
  logic [N_STAGES-1:0] rst_d;
  logic            ready_d;

  logic [1:0]      sync_q;
  logic [DW-1:0]   db_cnt_q;
  logic            btn_q;
  logic            btn_prev_q;
  logic            btn_rise;
  logic            ack_sel;

  // Button: two-flop synchroniser, then qualify on consecutive high samples;
  // any low sample drops the debounced level immediately.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q     <= 2'b00;
      db_cnt_q   <= '0;
      btn_q      <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], i_rst_button};
      btn_prev_q <= btn_q;
      if (!sync_q[1]) begin
        db_cnt_q <= '0;
        btn_q    <= 1'b0;
      end else if (db_cnt_q == DB_LAST) begin
        btn_q    <= 1'b1;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  assign btn_rise = btn_q & ~btn_prev_q;

  // i_ack is a level, not a pulse: a domain holds its bit high once it is out
  // of reset, and only the bit of the stage currently in WAIT_ACK is looked at.
  assign ack_sel = i_ack[stage_q];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // State register; o_rst/o_ready are registered from the next-state decode
  // so the domain resets never see combinational glitches.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_ASSERT;
      stage_q <= '0;
      cnt_q   <= '0;
      o_fault <= 1'b0;
      o_rst   <= '1;
      o_ready <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      o_fault <= fault_d;
      o_rst   <= rst_d;
      o_ready <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    fault_d = o_fault;
    if (btn_rise) begin
      state_d = ST_ASSERT;
      stage_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (btn_q) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = ST_WAIT_ACK;
            stage_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_WAIT_ACK: begin
          // Acknowledge takes priority over a coincident timeout.
          if (ack_sel || (cnt_q == TO_LAST)) begin
            if (!ack_sel) fault_d = 1'b1;
            cnt_d   = '0;
            state_d = (stage_q == LAST_STAGE) ? ST_RUN : ST_GAP;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_WAIT_ACK;
            stage_d = stage_q + 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

  // Domains 0..k are released while in WAIT_ACK(k)/GAP(k); higher ones stay held.
  always_comb begin
    rst_d   = '1;
    ready_d = 1'b0;
    case (state_d)
      ST_WAIT_ACK, ST_GAP: begin
        for (int i = 0; i < N_STAGES; i++) rst_d[i] = (i > int'(stage_d));
      end
      ST_RUN: begin
        rst_d   = '0;
        ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_dbg_state = state_q;
  assign o_dbg_stage = stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters; edge counts are
// hand-derived from the first clock edge after reset/restart (edge 1).
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b0;
  logic [2:0] ack = 3'b111;
  logic [2:0] o_rst;
  logic       o_ready;
  logic       o_fault;
  logic [1:0] o_dbg_state;
  logic [1:0] o_dbg_stage;

  int n_pass  = 0;
  int n_total = 0;

  reset_sequencer dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_rst_button (button),
    .i_ack        (ack),
    .o_rst        (o_rst),
    .o_ready      (o_ready),
    .o_fault      (o_fault),
    .o_dbg_state  (o_dbg_state),
    .o_dbg_stage  (o_dbg_stage)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is just past "edge 0": the next rising edge is ASSERT count edge 1, ack=111.
  task automatic expect_default_timing(input string tag);
    step(15);
    n_total++; if (o_rst !== 3'b111) $display("FAIL %s hold_e15: o_rst=%b exp=111", tag, o_rst); else n_pass++;
    n_total++; if (o_ready !== 1'b0) $display("FAIL %s ready_e15: o_ready=%b exp=0", tag, o_ready); else n_pass++;
    step(1);
    n_total++; if (o_rst !== 3'b110) $display("FAIL %s rst0_e16: o_rst=%b exp=110", tag, o_rst); else n_pass++;
    step(8);
    n_total++; if (o_rst !== 3'b110) $display("FAIL %s gap0_e24: o_rst=%b exp=110", tag, o_rst); else n_pass++;
    step(1);
    n_total++; if (o_rst !== 3'b100) $display("FAIL %s rst1_e25: o_rst=%b exp=100", tag, o_rst); else n_pass++;
    step(8);
    n_total++; if (o_rst !== 3'b100) $display("FAIL %s gap1_e33: o_rst=%b exp=100", tag, o_rst); else n_pass++;
    step(1);
    n_total++; if (o_rst !== 3'b000) $display("FAIL %s rst2_e34: o_rst=%b exp=000", tag, o_rst); else n_pass++;
    n_total++; if (o_ready !== 1'b0) $display("FAIL %s ready_e34: o_ready=%b exp=0", tag, o_ready); else n_pass++;
    step(1);
    n_total++; if (o_ready !== 1'b1) $display("FAIL %s ready_e35: o_ready=%b exp=1", tag, o_ready); else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ack = 3'b111; button = 1'b0;
    step(3);
    n_total++; if (o_rst !== 3'b111) $display("FAIL reset_rst: o_rst=%b exp=111", o_rst); else n_pass++;
    n_total++; if (o_ready !== 1'b0) $display("FAIL reset_ready: o_ready=%b exp=0", o_ready); else n_pass++;
    n_total++; if (o_fault !== 1'b0) $display("FAIL reset_fault: o_fault=%b exp=0", o_fault); else n_pass++;
    rst_n = 1'b1;
    expect_default_timing("power_up");
  endtask

  task automatic test_ack_in_run();
    for (int i = 0; i < 16; i++) begin
      ack = 3'($urandom_range(0, 7));
      step(1);
      n_total++; if (o_rst !== 3'b000 || o_ready !== 1'b1)
        $display("FAIL ack_in_run[%0d]: o_rst=%b o_ready=%b exp=000/1", i, o_rst, o_ready); else n_pass++;
    end
    ack = 3'b111;
  endtask

  task automatic test_button_pulses();
    button = 1'b1; #1; button = 1'b0;
    step(10);
    n_total++; if (o_rst !== 3'b000 || o_ready !== 1'b1)
      $display("FAIL glitch: o_rst=%b o_ready=%b exp=000/1", o_rst, o_ready); else n_pass++;
    button = 1'b1; step(3); button = 1'b0;
    step(10);
    n_total++; if (o_rst !== 3'b000 || o_ready !== 1'b1)
      $display("FAIL pulse3: o_rst=%b o_ready=%b exp=000/1", o_rst, o_ready); else n_pass++;
    button = 1'b1; step(4); button = 1'b0;
    step(2);
    n_total++; if (o_rst !== 3'b000 || o_ready !== 1'b1)
      $display("FAIL pulse4_latency: o_rst=%b o_ready=%b exp=000/1", o_rst, o_ready); else n_pass++;
    step(1);
    n_total++; if (o_rst !== 3'b111 || o_ready !== 1'b0)
      $display("FAIL pulse4_assert: o_rst=%b o_ready=%b exp=111/0", o_rst, o_ready); else n_pass++;
    expect_default_timing("pulse4");
  endtask

  task automatic test_button_hold();
    button = 1'b1;
    step(50);
    n_total++; if (o_rst !== 3'b111 || o_ready !== 1'b0)
      $display("FAIL hold_mid: o_rst=%b o_ready=%b exp=111/0", o_rst, o_ready); else n_pass++;
    step(50);
    n_total++; if (o_rst !== 3'b111)
      $display("FAIL hold_end: o_rst=%b exp=111", o_rst); else n_pass++;
    button = 1'b0;
    step(3);
    expect_default_timing("hold100");
  endtask

  task automatic test_timeout();
    rst_n = 1'b0; ack = 3'b101; #2; rst_n = 1'b1;
    step(16);
    n_total++; if (o_rst !== 3'b110) $display("FAIL to_rst0: o_rst=%b exp=110", o_rst); else n_pass++;
    step(9);
    n_total++; if (o_rst !== 3'b100) $display("FAIL to_rst1: o_rst=%b exp=100", o_rst); else n_pass++;
    step(254);
    n_total++; if (o_fault !== 1'b0) $display("FAIL to_early: o_fault=%b exp=0", o_fault); else n_pass++;
    step(1);
    n_total++; if (o_fault !== 1'b1) $display("FAIL to_fault: o_fault=%b exp=1", o_fault); else n_pass++;
    n_total++; if (o_rst !== 3'b100) $display("FAIL to_gap: o_rst=%b exp=100", o_rst); else n_pass++;
    step(7);
    n_total++; if (o_rst !== 3'b100) $display("FAIL to_e287: o_rst=%b exp=100", o_rst); else n_pass++;
    step(1);
    n_total++; if (o_rst !== 3'b000 || o_ready !== 1'b0)
      $display("FAIL to_e288: o_rst=%b o_ready=%b exp=000/0", o_rst, o_ready); else n_pass++;
    step(1);
    n_total++; if (o_ready !== 1'b1 || o_fault !== 1'b1)
      $display("FAIL to_ready: o_ready=%b o_fault=%b exp=1/1", o_ready, o_fault); else n_pass++;
  endtask

  task automatic test_rst_in_gap();
    ack = 3'b111;
    button = 1'b1; step(4); button = 1'b0;
    step(3);
    n_total++; if (o_rst !== 3'b111 || o_fault !== 1'b1)
      $display("FAIL btn_keeps_fault: o_rst=%b o_fault=%b exp=111/1", o_rst, o_fault); else n_pass++;
    step(18);
    n_total++; if (o_rst !== 3'b110) $display("FAIL gap0_before: o_rst=%b exp=110", o_rst); else n_pass++;
    rst_n = 1'b0; #1;
    n_total++; if (o_rst !== 3'b111 || o_fault !== 1'b0 || o_ready !== 1'b0)
      $display("FAIL async_abort: o_rst=%b o_fault=%b o_ready=%b exp=111/0/0", o_rst, o_fault, o_ready); else n_pass++;
    #1; rst_n = 1'b1;
    expect_default_timing("after_abort");
  endtask

  task automatic test_ack_timeout_coincide();
    rst_n = 1'b0; ack = 3'b110; #2; rst_n = 1'b1;
    step(16);
    n_total++; if (o_rst !== 3'b110) $display("FAIL co_rst0: o_rst=%b exp=110", o_rst); else n_pass++;
    step(254);
    n_total++; if (o_rst !== 3'b110 || o_fault !== 1'b0)
      $display("FAIL co_ignore_other: o_rst=%b o_fault=%b exp=110/0", o_rst, o_fault); else n_pass++;
    ack = 3'b111;
    step(1);
    n_total++; if (o_fault !== 1'b0) $display("FAIL co_fault: o_fault=%b exp=0", o_fault); else n_pass++;
    step(7);
    n_total++; if (o_rst !== 3'b110) $display("FAIL co_e278: o_rst=%b exp=110", o_rst); else n_pass++;
    step(1);
    n_total++; if (o_rst !== 3'b100) $display("FAIL co_rst1: o_rst=%b exp=100", o_rst); else n_pass++;
    step(9);
    n_total++; if (o_rst !== 3'b000) $display("FAIL co_rst2: o_rst=%b exp=000", o_rst); else n_pass++;
    step(1);
    n_total++; if (o_ready !== 1'b1 || o_fault !== 1'b0)
      $display("FAIL co_ready: o_ready=%b o_fault=%b exp=1/0", o_ready, o_fault); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ack_in_run();
    test_button_pulses();
    test_button_hold();
    test_timeout();
    test_rst_in_gap();
    test_ack_timeout_coincide();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter N_STAGES, default 3, giving the number of sequenced reset domains (2..8).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 16, giving the cycles all resets are held after entry to ASSERT.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 8, giving the cycles between an acknowledge and the next stage release.
REQ-004 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive synchronised high samples that qualify the button.
REQ-005 The block SHALL have parameter ACK_TIMEOUT, default 255, giving the maximum cycles spent waiting for one stage acknowledge.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-007 The block SHALL have port i_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port i_rst_button, input, 1 bit, asynchronous active-high push-button reset request.
REQ-009 The block SHALL have port i_ack, input, N_STAGES bits, per-domain "out of reset" acknowledge, synchronous to clk.
REQ-010 The block SHALL have port o_rst, output, N_STAGES bits, active-high per-domain reset, with bit 0 released first.
REQ-011 The block SHALL have port o_ready, output, 1 bit, high when all domains are released and acknowledged.
REQ-012 The block SHALL have port o_fault, output, 1 bit, sticky flag indicating that at least one acknowledge timeout occurred.

Function
REQ-013 The block SHALL pass i_rst_button through a 2-flop synchroniser, then a counter that asserts btn_q after DEBOUNCE_CYCLES consecutive high samples and deasserts it on the first low sample.
REQ-014 The block SHALL implement FSM states ASSERT, WAIT_ACK(k), GAP(k) and RUN, with stage index k running from 0 to N_STAGES-1.
REQ-015 ASSERT SHALL hold o_rst all-ones and count to HOLD_CYCLES; on the edge the count completes, o_rst[0] SHALL clear and the FSM SHALL enter WAIT_ACK(0).
REQ-016 In ASSERT, the count SHALL reset to 0 while btn_q is high, so a held button holds all domains in reset.
REQ-017 WAIT_ACK(k) SHALL sample i_ack[k] from the first edge after o_rst[k] falls; when it is sampled high, the FSM SHALL enter GAP(k) if k < N_STAGES-1, otherwise RUN.
REQ-018 GAP(k) SHALL last GAP_CYCLES cycles, and o_rst[k+1] SHALL fall exactly GAP_CYCLES edges after the edge on which i_ack[k] was sampled high.
REQ-019 o_ready SHALL be 1 from the edge after the last acknowledge is sampled, and only in RUN.
REQ-020 If i_ack[k] is not sampled high within ACK_TIMEOUT cycles in WAIT_ACK(k), the block SHALL set o_fault and proceed exactly as if acknowledged on that edge.
REQ-021 When acknowledge and timeout coincide, the acknowledge SHALL win and o_fault SHALL be left unchanged.
REQ-022 The block SHALL ignore i_ack bits for stages other than the one in WAIT_ACK, and SHALL ignore all i_ack bits in ASSERT, GAP and RUN.
REQ-023 In any state, btn_q rising SHALL, on the next edge, set o_rst all-ones, clear o_ready, zero the counters and enter ASSERT.
REQ-024 A button event SHALL NOT clear o_fault; only i_rst_n clears it.
REQ-025 Released bits of o_rst SHALL stay low until ASSERT is re-entered, so release is monotonic per sequence.
REQ-026 The block SHALL use a single shared cycle counter, at least clog2(max(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT)+1) bits wide, that saturates and never wraps.

Reset
REQ-027 i_rst_n low SHALL asynchronously force o_rst all-ones, o_ready=0, o_fault=0, state ASSERT, all counters and synchroniser/debounce flops to 0.
REQ-028 The sequence SHALL restart from ASSERT count 0 on the first edge with i_rst_n high, and that edge SHALL be counted as edge 1.
REQ-029 i_rst_n asserted mid-sequence, in any state, SHALL abort the sequence immediately without waiting for a clock edge.

Verification
REQ-030 Power-up with default parameters and i_ack=3'b111 SHALL produce o_rst[0] falling at edge 16, o_rst[1] at edge 25, o_rst[2] at edge 34, and o_ready=1 at edge 35.
REQ-031 i_ack[1] held low SHALL produce o_fault=1 exactly 255 cycles after entering WAIT_ACK(1), followed by o_rst[2] falling 8 edges later, and o_ready still reaching 1.
REQ-032 A 1 ns button glitch or a 3-cycle button pulse in RUN SHALL cause no change, while a 4-cycle pulse SHALL set o_rst=3'b111 and o_ready=0, then repeat the REQ-030 timing.
REQ-033 A button held for 100 cycles SHALL keep o_rst=3'b111, with o_rst[0] falling 16 edges after the debounced release.
REQ-034 i_rst_n pulsed low during GAP(0) SHALL immediately set o_rst=3'b111 and clear o_fault, and the REQ-030 timing SHALL then repeat.
REQ-035 i_ack[0] and the timeout occurring on the same edge SHALL leave o_fault=0, and i_ack toggling in RUN SHALL leave o_rst and o_ready unchanged.
